// File: rtl/mtm_alu_serializer.sv
// Output stage of the mtm ALU: turns one result or error report into the serial response on sout.
// Optional build macro MTM_ALU_SER_GAP_EN inserts one idle bit between frames of a data packet.
module mtm_alu_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  input  logic        err_valid,
  input  logic [31:0] data_C,
  input  logic [3:0]  flags,
  input  logic [5:0]  err_flags,
  output logic        tx_ready,
  output logic        sout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [54:0] shreg, shreg_nxt;
  logic [5:0]  bit_cnt, bit_cnt_nxt;
  logic        sout_nxt;
  logic        tx_ready_nxt;

`ifdef MTM_ALU_SER_GAP_EN
  logic [3:0]  frame_pos, frame_pos_nxt;
`endif

  logic [2:0]  crc_w;
  logic        parity_w;
  logic [54:0] data_pkt;
  logic [54:0] err_pkt;

  // CRC-3, x^3+x+1, init 000, message consumed MSB-first
  function automatic logic [2:0] crc3(input logic [36:0] msg);
    logic [2:0] crc;
    logic       fb;
    crc = '0;
    for (int unsigned i = 0; i < 37; i++) begin
      fb  = crc[2] ^ msg[36 - i];
      crc = {crc[1], crc[0] ^ fb, fb};
    end
    return crc;
  endfunction

  function automatic logic [10:0] frame(input logic typ, input logic [7:0] payload);
    return {1'b0, typ, payload, 1'b1};
  endfunction

  always_comb begin
    crc_w    = crc3({data_C, 1'b0, flags});
    parity_w = ^{1'b1, err_flags};
    data_pkt = {frame(1'b0, data_C[31:24]),
                frame(1'b0, data_C[23:16]),
                frame(1'b0, data_C[15:8]),
                frame(1'b0, data_C[7:0]),
                frame(1'b1, {1'b0, flags, crc_w})};
    err_pkt  = {frame(1'b1, {1'b1, err_flags, parity_w}), 44'd0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      sout     <= 1'b1;
      tx_ready <= 1'b1;
`ifdef MTM_ALU_SER_GAP_EN
      frame_pos <= '0;
`endif
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      sout     <= sout_nxt;
      tx_ready <= tx_ready_nxt;
`ifdef MTM_ALU_SER_GAP_EN
      frame_pos <= frame_pos_nxt;
`endif
    end
  end

  // The first bit goes straight into the sout flop at load, so bit_cnt counts
  // the remaining bits including the one currently on the line.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    sout_nxt     = sout;
    tx_ready_nxt = tx_ready;
`ifdef MTM_ALU_SER_GAP_EN
    frame_pos_nxt = frame_pos;
`endif

    case (state)
      IDLE: begin
        sout_nxt     = 1'b1;
        tx_ready_nxt = 1'b1;
        if (err_valid) begin
          sout_nxt     = err_pkt[54];
          shreg_nxt    = {err_pkt[53:0], 1'b0};
          bit_cnt_nxt  = 6'd11;
          tx_ready_nxt = 1'b0;
          state_nxt    = SEND;
`ifdef MTM_ALU_SER_GAP_EN
          frame_pos_nxt = '0;
`endif
        end else if (tx_valid) begin
          sout_nxt     = data_pkt[54];
          shreg_nxt    = {data_pkt[53:0], 1'b0};
          bit_cnt_nxt  = 6'd55;
          tx_ready_nxt = 1'b0;
          state_nxt    = SEND;
`ifdef MTM_ALU_SER_GAP_EN
          frame_pos_nxt = '0;
`endif
        end
      end

      SEND: begin
        tx_ready_nxt = 1'b0;
        if (bit_cnt == 6'd1) begin
          sout_nxt     = 1'b1;
          tx_ready_nxt = 1'b1;
          bit_cnt_nxt  = '0;
          state_nxt    = IDLE;
`ifdef MTM_ALU_SER_GAP_EN
        end else if (frame_pos == 4'd10) begin
          // stop bit just finished and more frames follow: idle one bit
          sout_nxt    = 1'b1;
          bit_cnt_nxt = bit_cnt - 6'd1;
          state_nxt   = GAP;
`endif
        end else begin
          sout_nxt    = shreg[54];
          shreg_nxt   = {shreg[53:0], 1'b0};
          bit_cnt_nxt = bit_cnt - 6'd1;
`ifdef MTM_ALU_SER_GAP_EN
          frame_pos_nxt = frame_pos + 4'd1;
`endif
        end
      end

`ifdef MTM_ALU_SER_GAP_EN
      GAP: begin
        tx_ready_nxt  = 1'b0;
        sout_nxt      = shreg[54];
        shreg_nxt     = {shreg[53:0], 1'b0};
        frame_pos_nxt = '0;
        state_nxt     = SEND;
      end
`endif

      default: begin
        sout_nxt     = 1'b1;
        tx_ready_nxt = 1'b1;
        state_nxt    = IDLE;
      end
    endcase
  end

endmodule
